pong_game_ctrl: RTL and testbench



---
 rtl/pong_game_ctrl.sv | 148 ++++++++++++++
 tb/tb_pong_game_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: game-state controller for a two-player pong game
// Ports:
//   clk, rst_n                         clock (pixel clock) and synchronous active-low reset
//   left_up/left_down/right_up/right_down, start   asynchronous active-high buttons
//   frame_tick                         one-cycle pulse per video frame
//   miss_left, miss_right              one-cycle pulses when the ball leaves the field
//   left_y, right_y                    paddle top positions
//   ball_run, ball_reset, serve_dir    ball datapath controls
//   score_left, score_right, game_over scoring
//   state                              IDLE=0 SERVE=1 PLAY=2 OVER=3
module pong_game_ctrl #(
   parameter int PADDLE_MAX   = 100,
   parameter int PADDLE_STEP  = 2,
   parameter int SERVE_FRAMES = 60,
   parameter int WIN_SCORE    = 9
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       left_up,
   input  logic       left_down,
   input  logic       right_up,
   input  logic       right_down,
   input  logic       start,
   input  logic       frame_tick,
   input  logic       miss_left,
   input  logic       miss_right,
   output logic [6:0] left_y,
   output logic [6:0] right_y,
   output logic       ball_run,
   output logic       ball_reset,
   output logic       serve_dir,
   output logic [3:0] score_left,
   output logic [3:0] score_right,
   output logic       game_over,
   output logic [2:0] state
);
   typedef enum logic [2:0] {IDLE = 3'd0, SERVE = 3'd1, PLAY = 3'd2, OVER = 3'd3} state_t;
   state_t     state_q, state_d;
   // bit order: {start, left_up, left_down, right_up, right_down}
   logic [4:0] sync1_q, sync1_d, sync2_q, sync2_d;
   logic       start_prev_q, start_prev_d;
   logic       start_press;
   logic [7:0] cnt_q, cnt_d;
   logic [6:0] left_y_q, left_y_d, right_y_q, right_y_d;
   logic [3:0] score_left_q, score_left_d, score_right_q, score_right_d;
   logic       serve_dir_q, serve_dir_d, ball_reset_q, ball_reset_d;
   logic       ball_run_q, ball_run_d, game_over_q, game_over_d;

   // 8-bit arithmetic keeps y-STEP and y+STEP from wrapping before saturation
   function automatic logic [6:0] move(input logic [6:0] y, input logic up, input logic dn);
      logic [7:0] w;
      w = {1'b0, y};
      if (up && !dn) return (w < 8'(PADDLE_STEP)) ? 7'd0 : 7'(w - 8'(PADDLE_STEP));
      if (dn && !up) return (w + 8'(PADDLE_STEP) > 8'(PADDLE_MAX)) ? 7'(PADDLE_MAX) : 7'(w + 8'(PADDLE_STEP));
      return y;
   endfunction

   assign start_press = sync2_q[4] && !start_prev_q;

   always_comb begin
      sync1_d       = {start, left_up, left_down, right_up, right_down};
      sync2_d       = sync1_q;
      start_prev_d  = sync2_q[4];
      state_d       = state_q;
      cnt_d         = cnt_q;
      left_y_d      = left_y_q;
      right_y_d     = right_y_q;
      score_left_d  = score_left_q;
      score_right_d = score_right_q;
      serve_dir_d   = serve_dir_q;
      if (frame_tick && (state_q == SERVE || state_q == PLAY)) begin
         left_y_d  = move(left_y_q, sync2_q[3], sync2_q[2]);
         right_y_d = move(right_y_q, sync2_q[1], sync2_q[0]);
      end
      case (state_q)
         IDLE, OVER: if (start_press) begin
            state_d       = SERVE;
            score_left_d  = 4'd0;
            score_right_d = 4'd0;
            serve_dir_d   = 1'b1;
         end
         SERVE: if (frame_tick) begin
            if (cnt_q == 8'(SERVE_FRAMES - 1)) state_d = PLAY;
            else cnt_d = cnt_q + 8'd1;
         end
         PLAY: begin
            if (miss_left && miss_right) state_d = SERVE;
            else if (miss_left) begin
               score_right_d = score_right_q + 4'd1;
               serve_dir_d   = 1'b0;
               state_d       = (score_right_d == 4'(WIN_SCORE)) ? OVER : SERVE;
            end else if (miss_right) begin
               score_left_d = score_left_q + 4'd1;
               serve_dir_d  = 1'b1;
               state_d      = (score_left_d == 4'(WIN_SCORE)) ? OVER : SERVE;
            end
         end
         default: state_d = IDLE;
      endcase
      // entering SERVE restarts the serve delay and recentres the ball
      ball_reset_d = (state_d == SERVE) && (state_q != SERVE);
      cnt_d        = ball_reset_d ? 8'd0 : cnt_d;
      ball_run_d   = state_d == PLAY;
      game_over_d  = state_d == OVER;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         sync1_q       <= '0;
         sync2_q       <= '0;
         start_prev_q  <= 1'b0;
         cnt_q         <= '0;
         left_y_q      <= 7'(PADDLE_MAX / 2);
         right_y_q     <= 7'(PADDLE_MAX / 2);
         score_left_q  <= '0;
         score_right_q <= '0;
         serve_dir_q   <= 1'b0;
         ball_reset_q  <= 1'b0;
         ball_run_q    <= 1'b0;
         game_over_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         start_prev_q  <= start_prev_d;
         cnt_q         <= cnt_d;
         left_y_q      <= left_y_d;
         right_y_q     <= right_y_d;
         score_left_q  <= score_left_d;
         score_right_q <= score_right_d;
         serve_dir_q   <= serve_dir_d;
         ball_reset_q  <= ball_reset_d;
         ball_run_q    <= ball_run_d;
         game_over_q   <= game_over_d;
      end
   end

   assign left_y      = left_y_q;
   assign right_y     = right_y_q;
   assign ball_run    = ball_run_q;
   assign ball_reset  = ball_reset_q;
   assign serve_dir   = serve_dir_q;
   assign score_left  = score_left_q;
   assign score_right = score_right_q;
   assign game_over   = game_over_q;
   assign state       = state_q;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed stimulus with a cycle model of the game rules and literal spot checks
module tb_pong_game_ctrl;
   localparam int PMAX = 100, STEP = 2, SF = 60, WIN = 9;
   logic clk = 1'b0, rst_n = 1'b0;
   logic left_up = 0, left_down = 0, right_up = 0, right_down = 0, start = 0;
   logic frame_tick = 0, miss_left = 0, miss_right = 0;
   logic [6:0] left_y, right_y;
   logic ball_run, ball_reset, serve_dir, game_over;
   logic [3:0] score_left, score_right;
   logic [2:0] state;
   int checks = 0, errors = 0;

   pong_game_ctrl #(.PADDLE_MAX(PMAX), .PADDLE_STEP(STEP), .SERVE_FRAMES(SF), .WIN_SCORE(WIN)) dut (
      .clk(clk), .rst_n(rst_n), .left_up(left_up), .left_down(left_down), .right_up(right_up),
      .right_down(right_down), .start(start), .frame_tick(frame_tick), .miss_left(miss_left),
      .miss_right(miss_right), .left_y(left_y), .right_y(right_y), .ball_run(ball_run),
      .ball_reset(ball_reset), .serve_dir(serve_dir), .score_left(score_left),
      .score_right(score_right), .game_over(game_over), .state(state));

   always #5 clk = ~clk;

   // model: game rules over integers; buttons seen two edges late, start press needs a 0->1 in that delayed view
   int ms, mcnt, mly, mry, msl, msr;
   bit mdir, mbr, mvalid;
   bit [2:0] hs;
   bit [3:0] hb0, hb1;

   function automatic int mv(int y, bit up, bit dn);
      if (up && !dn) return (y - STEP < 0) ? 0 : y - STEP;
      if (dn && !up) return (y + STEP > PMAX) ? PMAX : y + STEP;
      return y;
   endfunction

   always @(posedge clk) begin : mdl
      int s, c, ly, ry, sl, sr;
      bit d, br, press;
      if (!rst_n) begin
         ms <= 0; mcnt <= 0; mly <= PMAX / 2; mry <= PMAX / 2; msl <= 0; msr <= 0;
         mdir <= 0; mbr <= 0; hs <= '0; hb0 <= '0; hb1 <= '0; mvalid <= 1;
      end else begin
         s = ms; c = mcnt; ly = mly; ry = mry; sl = msl; sr = msr; d = mdir; br = 0;
         press = hs[1] && !hs[2];
         if (frame_tick && (s == 1 || s == 2)) begin
            ly = mv(ly, hb1[3], hb1[2]);
            ry = mv(ry, hb1[1], hb1[0]);
         end
         if ((s == 0 || s == 3) && press) begin
            sl = 0; sr = 0; d = 1; s = 1; c = 0; br = 1;
         end else if (s == 1 && frame_tick) begin
            if (c + 1 == SF) s = 2; else c++;
         end else if (s == 2 && (miss_left || miss_right)) begin
            if (!(miss_left && miss_right)) begin
               if (miss_left) begin sr++; d = 0; end
               else begin sl++; d = 1; end
            end
            if (sl == WIN || sr == WIN) s = 3;
            else begin s = 1; c = 0; br = 1; end
         end
         ms <= s; mcnt <= c; mly <= ly; mry <= ry; msl <= sl; msr <= sr; mdir <= d; mbr <= br;
         hs <= {hs[1:0], start};
         hb1 <= hb0;
         hb0 <= {left_up, left_down, right_up, right_down};
      end
   end

   always @(negedge clk) if (mvalid) begin
      checks++;
      if (state !== 3'(ms) || left_y !== 7'(mly) || right_y !== 7'(mry) || score_left !== 4'(msl) ||
          score_right !== 4'(msr) || serve_dir !== mdir || ball_reset !== mbr ||
          ball_run !== (ms == 2) || game_over !== (ms == 3)) begin
         errors++;
         $display("FAIL model t=%0t got st=%0d ly=%0d ry=%0d sl=%0d sr=%0d dir=%b brst=%b run=%b ovr=%b exp st=%0d ly=%0d ry=%0d sl=%0d sr=%0d dir=%b brst=%b run=%b ovr=%b",
                  $time, state, left_y, right_y, score_left, score_right, serve_dir, ball_reset, ball_run, game_over,
                  ms, mly, mry, msl, msr, mdir, mbr, ms == 2, ms == 3);
      end
   end

   task automatic chk(input string n, input int a, input int e);
      checks++;
      if (a != e) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", n, a, e);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic tick();
      frame_tick = 1; step(1); frame_tick = 0; step(1);
   endtask

   task automatic serve();
      repeat (SF) tick();
   endtask

   task automatic miss(input bit l, input bit r);
      miss_left = l; miss_right = r; step(1); miss_left = 0; miss_right = 0;
   endtask

   task automatic press_start();
      start = 1; step(5); start = 0; step(2);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      step(2);
      chk("rst_state", state, 0);
      chk("rst_left_y", left_y, 50);
      chk("rst_right_y", right_y, 50);
      chk("rst_scores", {score_left, score_right}, 0);
      rst_n = 1; step(2);
      start = 1;
      step(2);
      chk("start_edge2_idle", state, 0);
      step(1);
      chk("start_edge3_serve", state, 1);
      chk("start_ball_reset", ball_reset, 1);
      chk("start_serve_dir", serve_dir, 1);
      step(1);
      chk("ball_reset_one_cycle", ball_reset, 0);
      step(1); start = 0;
      repeat (SF - 1) tick();
      chk("serve_59_ticks", state, 1);
      tick();
      chk("serve_60_play", state, 2);
      chk("play_ball_run", ball_run, 1);
      left_up = 1; step(2);
      repeat (30) tick();
      chk("left_up_floor", left_y, 0);
      left_up = 0; right_down = 1; step(2);
      repeat (30) tick();
      chk("right_down_ceiling", right_y, 100);
      right_down = 0; left_down = 1; step(2);
      repeat (5) tick();
      chk("left_down_5", left_y, 10);
      left_up = 1; step(2);
      repeat (5) tick();
      chk("both_hold", left_y, 10);
      left_up = 0; left_down = 0; step(2);
      press_start(); step(2);
      chk("start_ignored_play", state, 2);
      miss(0, 1);
      chk("miss_right_score", score_left, 1);
      chk("miss_right_state", state, 1);
      chk("miss_right_reset", ball_reset, 1);
      chk("miss_right_dir", serve_dir, 1);
      miss(1, 0); step(1);
      chk("miss_in_serve_ignored", score_right, 0);
      serve();
      miss(1, 0);
      chk("miss_left_score", score_right, 1);
      chk("miss_left_dir", serve_dir, 0);
      serve();
      miss(1, 1);
      chk("double_miss_state", state, 1);
      chk("double_miss_scores", {score_left, score_right}, 8'h11);
      for (int i = 2; i <= WIN; i++) begin
         serve();
         miss(0, 1);
      end
      chk("win_state", state, 3);
      chk("win_game_over", game_over, 1);
      chk("win_score", score_left, 9);
      left_up = 1; step(2); repeat (3) tick(); left_up = 0;
      chk("over_paddle_hold", left_y, 10);
      press_start();
      chk("restart_state", state, 1);
      chk("restart_scores", {score_left, score_right}, 0);
      serve(); miss(0, 1);
      serve(); miss(0, 1);
      serve(); miss(0, 1);
      serve(); miss(1, 0);
      serve(); miss(1, 0);
      serve();
      chk("score_3_2", {score_left, score_right}, 8'h32);
      chk("score_3_2_play", state, 2);
      rst_n = 0; step(1); rst_n = 1;
      chk("midgame_rst_state", state, 0);
      chk("midgame_rst_scores", {score_left, score_right}, 0);
      chk("midgame_rst_paddles", {left_y, right_y}, {7'd50, 7'd50});
      chk("midgame_rst_run", ball_run, 0);
      chk("midgame_rst_no_pulse", ball_reset, 0);
      step(3);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
